piobp_irq_sequencer: RTL and testbench
======================================

PIOBP_IRQ_SEQUENCER -- requirements
Module: piobp_irq_sequencer

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, event FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter: TS_WIDTH, 16, timestamp width.
REQ-003 SHALL have parameter: HOLDOFF_CYCLES, 50000, lockout length in clk cycles (>=1).
REQ-004 SHALL have one clock and a synchronous, active-low reset:
  clk  in  1  system clock, all logic on rising edge
  reset_n  in  1  synchronous active-low reset
  pio_address  out  2  PIO register select
  pio_chipselect  out  1  PIO access strobe
  pio_write_n  out  1  PIO write, active-low
  pio_writedata  out  32  PIO write data
  pio_readdata  in  32  PIO read data, registered, valid 1 cycle after address
  pio_irq  in  1  PIO interrupt, level
  evt_valid  out  1  event FIFO non-empty
  evt_ready  in  1  consumer pop
  evt_data  out  TS_WIDTH+1  {button level, timestamp} at FIFO head
  drop_cnt  out  8  events lost to full FIFO, saturating
  busy  out  1  high in any state except IDLE

Function
REQ-005 PIO map SHALL be: addr 0 data (bit0 = button level), addr 2 irq mask, addr 3 edge capture (any write clears).
REQ-006 Write cycle SHALL be one clk with pio_chipselect=1, pio_write_n=0; otherwise pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-007 States SHALL be INIT_CLR, INIT_MASK, IDLE, RD_DATA, RD_WAIT, CLR, PUSH, one clk each except IDLE (and HOLD, REQ-018).
REQ-008 INIT_CLR: write addr 3 data 0 -> INIT_MASK: write addr 2 data 1 -> IDLE.
REQ-009 IDLE: pio_address=0; on pio_irq=1 latch ts_cnt into ts_reg, go RD_DATA.
REQ-010 RD_DATA: pio_address=0 read -> RD_WAIT: latch pio_readdata[0] into lvl_reg -> CLR: write addr 3 data 0 -> PUSH.
REQ-011 PUSH: write {lvl_reg, ts_reg} into FIFO if not full, else drop_cnt+1 (holds at 255); -> IDLE.
REQ-012 irq-to-push latency SHALL be 4 clk (IDLE detect, RD_DATA, RD_WAIT, CLR; write at PUSH edge); evt_valid rises the cycle after PUSH when FIFO was empty.
REQ-013 ts_cnt SHALL be a free-running TS_WIDTH counter, +1 every clk, wrapping all-ones -> 0.
REQ-014 FIFO SHALL be first-word-fall-through; evt_data = head entry, pop when evt_valid && evt_ready; evt_ready with FIFO empty ignored.
REQ-015 Push and pop in same cycle SHALL both take effect, including when full (push accepted, no drop).
REQ-016 pio_irq reasserting during RD_DATA..PUSH SHALL be serviced from IDLE afterwards; edges arriving before CLR merge into the current event.

Reset
REQ-017 reset_n=0 at a clk edge SHALL set state INIT_CLR, FIFO empty, evt_valid 0, drop_cnt 0, ts_cnt 0, ts_reg 0, lvl_reg 0, hold counter 0, busy 1, pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0; reset mid-sequence abandons the event and reinitialises PIO via INIT_CLR/INIT_MASK.

Configuration
REQ-018 Macro PIOBP_HOLDOFF_EN defined: PUSH -> MASK_OFF (write addr 2 data 0) -> HOLD (HOLDOFF_CYCLES clk, counter counts down to 0) -> HOLD_CLR (write addr 3 data 0) -> MASK_ON (write addr 2 data 1) -> IDLE; edges during lockout discarded, busy high throughout.
REQ-019 Macro PIOBP_HOLDOFF_EN undefined: PUSH -> IDLE, no MASK_OFF/HOLD/HOLD_CLR/MASK_ON states or hold counter, HOLDOFF_CYCLES unused.

Verification
REQ-020 Reset release -> write addr3 data0 next cycle, write addr2 data1 following cycle, then IDLE with busy=0.
REQ-021 pio_irq pulse at ts_cnt=0x0100, PIO data bit0=0 -> evt_valid rises 5 clk later, evt_data=0x0_0100, one addr3 clear write seen.
REQ-022 Five events with evt_ready=0, FIFO_DEPTH=4 -> 4 entries held in order, drop_cnt=1; 300 further events -> drop_cnt=255.
REQ-023 FIFO full, evt_ready=1 in the PUSH cycle -> head popped, new event stored, drop_cnt unchanged.
REQ-024 ts_cnt=0xFFFF at irq detect -> evt_data timestamp 0xFFFF, next ts_cnt 0x0000.
REQ-025 With PIOBP_HOLDOFF_EN, HOLDOFF_CYCLES=10, second irq 3 clk into HOLD -> no second event, addr3 clear then mask=1 writes after 10 hold cycles.

Source files
------------

// File: rtl/piobp_irq_sequencer.sv
// piobp_irq_sequencer
//
// Services a push-button PIO peripheral.
//
// After reset the sequencer clears the PIO edge-capture register and enables
// the PIO interrupt mask. Each interrupt then produces one event: the button
// level is read, the edge capture is cleared, and {level, timestamp} is
// pushed into a first-word-fall-through event FIFO. The timestamp is the
// free-running cycle counter value at the moment the interrupt was seen.
//
// All PIO bus outputs are registered. The bus action chosen in a state is
// therefore visible on the pins during the following cycle.
//
// Optional feature (macro PIOBP_HOLDOFF_EN): after each push the interrupt
// is masked for HOLDOFF_CYCLES clocks (debounce lockout), the edge capture
// is cleared again and the mask is re-enabled. Edges inside the lockout are
// discarded. Without the macro the sequencer returns straight to IDLE and
// HOLDOFF_CYCLES has no effect.
//
// Parameters
//   FIFO_DEPTH      event FIFO entries (power of 2, 2..16)
//   TS_WIDTH        timestamp width
//   HOLDOFF_CYCLES  lockout length in clk cycles (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   reset_n         synchronous active-low reset
//   pio_address     PIO register select (0 data, 2 irq mask, 3 edge capture)
//   pio_chipselect  PIO write strobe
//   pio_write_n     PIO write, active-low
//   pio_writedata   PIO write data
//   pio_readdata    PIO read data, valid one cycle after the address
//   pio_irq         PIO interrupt, level
//   evt_valid       event FIFO not empty
//   evt_ready       consumer pop (ignored while empty)
//   evt_data        {button level, timestamp} at the FIFO head
//   drop_cnt        events lost to a full FIFO, saturating at 255
//   busy            high in every state except IDLE

module piobp_irq_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TS_WIDTH       = 16,
    parameter int HOLDOFF_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [1:0]          pio_address,
    output logic                pio_chipselect,
    output logic                pio_write_n,
    output logic [31:0]         pio_writedata,
    input  logic [31:0]         pio_readdata,
    input  logic                pio_irq,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [TS_WIDTH:0]   evt_data,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;
    localparam int EW    = TS_WIDTH + 1;

    typedef enum logic [3:0] {
        S_INIT_CLR,
        S_INIT_MASK,
        S_IDLE,
        S_RD_DATA,
        S_RD_WAIT,
        S_CLR,
        S_PUSH
`ifdef PIOBP_HOLDOFF_EN
        ,
        S_MASK_OFF,
        S_HOLD,
        S_HOLD_CLR,
        S_MASK_ON
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0] ts_reg_q, ts_reg_d;
    logic                lvl_reg_q, lvl_reg_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [1:0]          pio_address_q, pio_address_d;
    logic                pio_chipselect_q, pio_chipselect_d;
    logic                pio_write_n_q, pio_write_n_d;
    logic [31:0]         pio_writedata_q, pio_writedata_d;
    logic                busy_q, busy_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];

`ifdef PIOBP_HOLDOFF_EN
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
`else
    localparam int unused_holdoff = HOLDOFF_CYCLES;
`endif

    // Only the button level bit of the PIO data register is consumed.
    logic unused_rd;
    assign unused_rd = ^pio_readdata[31:1];

    logic push, pop, full, push_ok;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && evt_ready;
    assign push    = (state_q == S_PUSH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);

    always_comb begin
        state_d          = state_q;
        ts_cnt_d         = ts_cnt_q + TS_WIDTH'(1);
        ts_reg_d         = ts_reg_q;
        lvl_reg_d        = lvl_reg_q;
        pio_address_d    = 2'd0;
        pio_chipselect_d = 1'b0;
        pio_write_n_d    = 1'b1;
        pio_writedata_d  = 32'd0;
`ifdef PIOBP_HOLDOFF_EN
        hold_cnt_d       = hold_cnt_q;
`endif
        case (state_q)
            S_INIT_CLR: begin
                pio_address_d    = 2'd3;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                state_d          = S_INIT_MASK;
            end
            S_INIT_MASK: begin
                pio_address_d    = 2'd2;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                pio_writedata_d  = 32'd1;
                state_d          = S_IDLE;
            end
            S_IDLE: begin
                if (pio_irq) begin
                    ts_reg_d = ts_cnt_q;
                    state_d  = S_RD_DATA;
                end
            end
            S_RD_DATA: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                lvl_reg_d = pio_readdata[0];
                state_d   = S_CLR;
            end
            S_CLR: begin
                pio_address_d    = 2'd3;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                state_d          = S_PUSH;
            end
`ifdef PIOBP_HOLDOFF_EN
            S_PUSH: state_d = S_MASK_OFF;
            S_MASK_OFF: begin
                pio_address_d    = 2'd2;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                hold_cnt_d       = HW'(HOLDOFF_CYCLES - 1);
                state_d          = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_HOLD_CLR;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            S_HOLD_CLR: begin
                pio_address_d    = 2'd3;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                state_d          = S_MASK_ON;
            end
            S_MASK_ON: begin
                pio_address_d    = 2'd2;
                pio_chipselect_d = 1'b1;
                pio_write_n_d    = 1'b0;
                pio_writedata_d  = 32'd1;
                state_d          = S_IDLE;
            end
`else
            S_PUSH: state_d = S_IDLE;
`endif
            default: state_d = S_INIT_CLR;
        endcase

        busy_d = (state_d != S_IDLE);

        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        drop_cnt_d = drop_cnt_q;
        if (push && !push_ok && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_INIT_CLR;
            ts_cnt_q         <= '0;
            ts_reg_q         <= '0;
            lvl_reg_q        <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            drop_cnt_q       <= 8'd0;
            pio_address_q    <= 2'd0;
            pio_chipselect_q <= 1'b0;
            pio_write_n_q    <= 1'b1;
            pio_writedata_q  <= 32'd0;
            busy_q           <= 1'b1;
`ifdef PIOBP_HOLDOFF_EN
            hold_cnt_q       <= '0;
`endif
        end else begin
            state_q          <= state_d;
            ts_cnt_q         <= ts_cnt_d;
            ts_reg_q         <= ts_reg_d;
            lvl_reg_q        <= lvl_reg_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            drop_cnt_q       <= drop_cnt_d;
            pio_address_q    <= pio_address_d;
            pio_chipselect_q <= pio_chipselect_d;
            pio_write_n_q    <= pio_write_n_d;
            pio_writedata_q  <= pio_writedata_d;
            busy_q           <= busy_d;
`ifdef PIOBP_HOLDOFF_EN
            hold_cnt_q       <= hold_cnt_d;
`endif
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {lvl_reg_q, ts_reg_q};
        end
    end

    assign pio_address    = pio_address_q;
    assign pio_chipselect = pio_chipselect_q;
    assign pio_write_n    = pio_write_n_q;
    assign pio_writedata  = pio_writedata_q;
    assign evt_valid      = (count_q != '0);
    assign evt_data       = mem_q[rd_ptr_q];
    assign drop_cnt       = drop_cnt_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_piobp_irq_sequencer.sv
module tb_piobp_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'd0;
    logic        pio_irq;
    logic        evt_valid;
    logic        evt_ready;
    logic [16:0] evt_data;
    logic [7:0]  drop_cnt;
    logic        busy;

`ifdef PIOBP_HOLDOFF_EN
    localparam int GAP     = 20;
    localparam int MIN_GAP = 19;
`else
    localparam int GAP     = 8;
    localparam int MIN_GAP = 5;
`endif

    piobp_irq_sequencer #(
        .FIFO_DEPTH     (4),
        .TS_WIDTH       (16),
        .HOLDOFF_CYCLES (10)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          bad_idle  = 0;
    logic        mon_en    = 1'b0;
    logic [15:0] ts_model  = 16'd0;
    logic        edge_req  = 1'b0;
    logic        btn       = 1'b0;
    logic        pio_mask  = 1'b0;
    logic        pio_edge  = 1'b0;
    logic [15:0] tsv [6];

    typedef struct {
        int          c;
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];

    // PIO peripheral model, bus monitor and reference timestamp counter
    assign pio_irq = pio_edge & pio_mask;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ts_model <= !reset_n ? 16'd0 : ts_model + 16'd1;
        pio_readdata <= (pio_address == 2'd0) ? {31'd0, btn} : 32'd0;
        if (mon_en) begin
            if (pio_chipselect && !pio_write_n)
                wlog.push_back('{cyc, pio_address, pio_writedata});
            else if (pio_chipselect || !pio_write_n || pio_writedata != 32'd0)
                bad_idle <= bad_idle + 1;
        end
        if (!reset_n) begin
            pio_mask <= 1'b0;
            pio_edge <= 1'b0;
        end else begin
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
                pio_mask <= pio_writedata[0];
            if (edge_req)
                pio_edge <= 1'b1;
            else if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
                pio_edge <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a button edge; returns at the first cycle pio_irq is high.
    task automatic fire(output int d, output logic [15:0] ts);
        edge_req = 1'b1;
        tick();
        edge_req = 1'b0;
        d  = cyc;
        ts = ts_model;
    endtask

    task automatic do_event(input logic lvl, output logic [15:0] ts);
        int d;
        btn = lvl;
        fire(d, ts);
        repeat (GAP) tick();
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic wait_ts(input logic [15:0] t);
        int n = 0;
        while (ts_model !== t && n < 70000) begin
            tick();
            n++;
        end
        tests_run++;
        if (ts_model !== t) begin
            failures++;
            $display("FAIL wait_ts: ts=%h required=%h", ts_model, t);
        end
    endtask

    task automatic test_reset();
        int r;
        reset_n   = 1'b0;
        evt_ready = 1'b0;
        repeat (3) tick();
        mon_en = 1'b1;
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_evt_valid: got %b want 0", evt_valid); end
        tests_run++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop_cnt: got %h want 00", drop_cnt); end
        tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b want 1", busy); end
        tests_run++; if (pio_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs: got %b want 0", pio_chipselect); end
        tests_run++; if (pio_write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n: got %b want 1", pio_write_n); end
        tests_run++; if (pio_address !== 2'd0) begin failures++; $display("FAIL rst_addr: got %h want 0", pio_address); end
        tests_run++; if (pio_writedata !== 32'd0) begin failures++; $display("FAIL rst_wdata: got %h want 0", pio_writedata); end
        r = cyc;
        wlog.delete();
        reset_n = 1'b1;
        tick();
        tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL init_busy: got %b want 1", busy); end
        repeat (3) tick();
        tests_run++; if (wlog.size() !== 2) begin failures++; $display("FAIL init_nwrites: got %0d want 2", wlog.size()); end
        if (wlog.size() >= 2) begin
            tests_run++;
            if (wlog[0].c !== r + 1 || wlog[0].a !== 2'd3 || wlog[0].d !== 32'd0) begin
                failures++;
                $display("FAIL init_clr: got cyc=%0d a=%0d d=%h want cyc=%0d a=3 d=0", wlog[0].c, wlog[0].a, wlog[0].d, r + 1);
            end
            tests_run++;
            if (wlog[1].c !== r + 2 || wlog[1].a !== 2'd2 || wlog[1].d !== 32'd1) begin
                failures++;
                $display("FAIL init_mask: got cyc=%0d a=%0d d=%h want cyc=%0d a=2 d=1", wlog[1].c, wlog[1].a, wlog[1].d, r + 2);
            end
        end
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_event();
        int d;
        int nclr = 0;
        int cclr = -1;
        logic [15:0] t;
        btn = 1'b0;
        wait_ts(16'h00FF);
        wlog.delete();
        fire(d, t);
        repeat (4) tick();
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", evt_valid); end
        tick();
        tests_run++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        tests_run++; if (evt_data !== 17'h0_0100) begin failures++; $display("FAIL single_data: got %h want 00100", evt_data); end
        foreach (wlog[i]) if (wlog[i].a == 2'd3) begin nclr++; cclr = wlog[i].c; end
        tests_run++;
        if (nclr !== 1 || cclr !== d + 4) begin
            failures++;
            $display("FAIL single_clear: got n=%0d cyc=%0d want n=1 cyc=%0d", nclr, cclr, d + 4);
        end
        pop();
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_pop: got %b want 0", evt_valid); end
        repeat (GAP) tick();
    endtask

    task automatic test_level_and_empty_ready();
        logic [15:0] t;
        do_event(1'b1, t);
        tests_run++; if (evt_data !== {1'b1, t}) begin failures++; $display("FAIL level_hi: got %h want %h", evt_data, {1'b1, t}); end
        pop();
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL empty_ready_valid: got %b want 0", evt_valid); end
        do_event(1'b0, t);
        tests_run++; if (evt_valid !== 1'b1 || evt_data !== {1'b0, t}) begin failures++; $display("FAIL empty_ready_evt: got v=%b %h want v=1 %h", evt_valid, evt_data, {1'b0, t}); end
        pop();
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL empty_ready_pop: got %b want 0", evt_valid); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 5; i++) do_event(i[0], tsv[i]);
        tests_run++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL full_drop: got %0d want 1", drop_cnt); end
        tests_run++; if (evt_data !== {1'b0, tsv[0]}) begin failures++; $display("FAIL full_head: got %h want %h", evt_data, {1'b0, tsv[0]}); end
    endtask

    task automatic test_push_pop_full();
        int d;
        btn = 1'b1;
        fire(d, tsv[5]);
        repeat (4) tick();
        pop();
        repeat (GAP) tick();
        tests_run++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL pushpop_drop: got %0d want 1", drop_cnt); end
        tests_run++; if (evt_data !== {1'b1, tsv[1]}) begin failures++; $display("FAIL pushpop_head: got %h want %h", evt_data, {1'b1, tsv[1]}); end
    endtask

    task automatic test_drop_saturate();
        logic [15:0] t;
        logic [16:0] exp [4];
        for (int i = 0; i < 300; i++) do_event(1'b0, t);
        tests_run++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
        exp[0] = {1'b1, tsv[1]};
        exp[1] = {1'b0, tsv[2]};
        exp[2] = {1'b1, tsv[3]};
        exp[3] = {1'b1, tsv[5]};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (evt_valid !== 1'b1 || evt_data !== exp[i]) begin
                failures++;
                $display("FAIL order_%0d: got v=%b %h want v=1 %h", i, evt_valid, evt_data, exp[i]);
            end
            pop();
        end
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL order_empty: got %b want 0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        int d;
        int d2;
        logic [15:0] ta;
        logic [15:0] tb;
        btn = 1'b0;
        fire(d, ta);
        tick();
        edge_req = 1'b1;
        tick();
        edge_req = 1'b0;
        repeat (GAP) tick();
        tests_run++; if (evt_valid !== 1'b1 || evt_data !== {1'b0, ta}) begin failures++; $display("FAIL merge_evt: got v=%b %h want v=1 %h", evt_valid, evt_data, {1'b0, ta}); end
        pop();
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL merge_single: got %b want 0", evt_valid); end
        fire(d, ta);
        repeat (MIN_GAP) tick();
        fire(d2, tb);
        repeat (GAP) tick();
        tests_run++; if (evt_data !== {1'b0, ta}) begin failures++; $display("FAIL b2b_first: got %h want %h", evt_data, {1'b0, ta}); end
        pop();
        tests_run++;
        if (evt_valid !== 1'b1 || evt_data !== {1'b0, ta + 16'(MIN_GAP + 1)}) begin
            failures++;
            $display("FAIL b2b_second: got v=%b %h want v=1 %h", evt_valid, evt_data, {1'b0, ta + 16'(MIN_GAP + 1)});
        end
        pop();
    endtask

    task automatic test_wrap();
        int d;
        logic [15:0] t;
        wait_ts(16'hFFFE);
        btn = 1'b1;
        fire(d, t);
        repeat (GAP) tick();
        tests_run++; if (evt_data !== 17'h1_FFFF) begin failures++; $display("FAIL wrap_ts: got %h want 1ffff", evt_data); end
        pop();
        btn = 1'b0;
        fire(d, t);
        repeat (GAP) tick();
        tests_run++; if (evt_data !== {1'b0, 16'(GAP + 1)}) begin failures++; $display("FAIL wrap_next: got %h want %h", evt_data, {1'b0, 16'(GAP + 1)}); end
        pop();
    endtask

`ifdef PIOBP_HOLDOFF_EN
    task automatic test_holdoff();
        int d;
        logic [15:0] t;
        wlog.delete();
        btn = 1'b0;
        fire(d, t);
        repeat (8) tick();
        edge_req = 1'b1;
        tick();
        edge_req = 1'b0;
        tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy: got %b want 1", busy); end
        repeat (20) tick();
        tests_run++; if (wlog.size() !== 4) begin failures++; $display("FAIL hold_nwrites: got %0d want 4", wlog.size()); end
        if (wlog.size() >= 4) begin
            tests_run++;
            if (wlog[1].c !== d + 6 || wlog[1].a !== 2'd2 || wlog[1].d !== 32'd0) begin
                failures++; $display("FAIL hold_maskoff: got cyc=%0d a=%0d d=%h want cyc=%0d a=2 d=0", wlog[1].c, wlog[1].a, wlog[1].d, d + 6);
            end
            tests_run++;
            if (wlog[2].c !== d + 17 || wlog[2].a !== 2'd3) begin
                failures++; $display("FAIL hold_clr: got cyc=%0d a=%0d want cyc=%0d a=3", wlog[2].c, wlog[2].a, d + 17);
            end
            tests_run++;
            if (wlog[3].c !== d + 18 || wlog[3].a !== 2'd2 || wlog[3].d !== 32'd1) begin
                failures++; $display("FAIL hold_maskon: got cyc=%0d a=%0d d=%h want cyc=%0d a=2 d=1", wlog[3].c, wlog[3].a, wlog[3].d, d + 18);
            end
        end
        tests_run++; if (evt_data !== {1'b0, t}) begin failures++; $display("FAIL hold_evt: got %h want %h", evt_data, {1'b0, t}); end
        pop();
        tests_run++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL hold_discard: got %b want 0", evt_valid); end
    endtask
`endif

    task automatic test_idle_bus();
        tests_run++;
        if (bad_idle !== 0) begin failures++; $display("FAIL idle_bus: got %0d bad cycles want 0", bad_idle); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_level_and_empty_ready();
        test_fifo_full();
        test_push_pop_full();
        test_drop_saturate();
        test_back_to_back();
`ifdef PIOBP_HOLDOFF_EN
        test_holdoff();
`endif
        test_wrap();
        test_idle_bus();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
